mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-requester (fetch / data) arbiter onto a single memory port.
// Exactly one transaction is in flight at a time. A 16-bit watchdog ends a
// transaction whose m_ack does not arrive within TIMEOUT busy cycles and
// returns it with rerr=1.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the data requester always wins ties.
module mem_arb #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RSTn,
    // fetch requester
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    // data requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    // shared response
    output logic [XLEN-1:0]   rdata,
    output logic              rerr,
    // memory port
    output logic              m_req,
    output logic              m_we,
    output logic [XLEN-1:0]   m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [XLEN/8-1:0] m_wstrb,
    input  logic              m_ack,
    input  logic [XLEN-1:0]   m_rdata
);

    localparam int unsigned SW = XLEN / 8;
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [XLEN-1:0]   m_addr_q, m_addr_d;
    logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
    logic [SW-1:0]     m_wstrb_q, m_wstrb_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [15:0]       wd_q, wd_d;
    logic [15:0]       wd_inc;
    logic              grant_i, grant_d;

`ifdef MEM_ARB_RR_EN
    // rr_q = 1 means the fetch side is preferred on the next tie
    logic              rr_q, rr_d;

    // Round-robin arbitration: grants only in IDLE and never during reset
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE && RSTn) begin
            if (i_req && d_req) begin
                grant_i = rr_q;
                grant_d = !rr_q;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // Pointer flips to favour whichever side was not just granted
    always_comb begin
        rr_d = rr_q;
        if (grant_d) begin
            rr_d = 1'b1;
        end else if (grant_i) begin
            rr_d = 1'b0;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed-priority arbitration: data over fetch, only in IDLE, never in reset
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE && RSTn) begin
            grant_d = d_req;
            grant_i = i_req && !d_req;
        end
    end
`endif

    assign wd_inc = wd_q + 16'd1;

    // Next-state: latch request at grant, complete on ack or watchdog expiry
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_wstrb_d = d_wstrb;
                    wd_d      = '0;
                end else if (grant_i) begin
                    state_d   = BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    m_wstrb_d = '0;
                    wd_d      = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // ack wins over an expiry landing in the same cycle
                if (m_ack) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    rdata_d    = m_rdata;
                    rerr_d     = 1'b0;
                    i_rvalid_d = (state_q == BUSY_I);
                    d_rvalid_d = (state_q == BUSY_D);
                end else if (wd_inc == TIMEOUT_W) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    rdata_d    = '0;
                    rerr_d     = 1'b1;
                    i_rvalid_d = (state_q == BUSY_I);
                    d_rvalid_d = (state_q == BUSY_D);
                    wd_d       = wd_inc;
                end else begin
                    wd_d = wd_inc;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, all cleared by asynchronous reset
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            rdata_q    <= '0;
            rerr_q     <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            wd_q       <= wd_d;
        end
    end

    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign rdata    = rdata_q;
    assign rerr     = rerr_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wstrb  = m_wstrb_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TO   = 6;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              i_req, d_req, d_we, m_ack;
    logic [XLEN-1:0]   i_addr, d_addr, d_wdata, m_rdata;
    logic [XLEN/8-1:0] d_wstrb;
    logic              i_gnt, i_rvalid, d_gnt, d_rvalid, rerr, m_req, m_we;
    logic [XLEN-1:0]   rdata, m_addr, m_wdata;
    logic [XLEN/8-1:0] m_wstrb;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // transaction model state
    bit              busy;
    bit              owner_d;
    logic            t_we;
    logic [63:0]     t_addr, t_wdata;
    logic [7:0]      t_wstrb;
    int unsigned     age;
    bit              rv_i, rv_d, rv_err;
    logic [63:0]     rv_data;
    bit              prefer_d;

    mem_arb #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .rerr(rerr),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy     = 0;
        age      = 0;
        rv_i     = 0;
        rv_d     = 0;
        rv_err   = 0;
        rv_data  = '0;
        prefer_d = 1;
    endtask

    // One clock cycle: drive inputs after the edge, check mid-cycle, advance model
    task automatic step(input logic ir, input logic [63:0] ia,
                        input logic dr, input logic dw, input logic [63:0] da,
                        input logic [63:0] dwd, input logic [7:0] ds,
                        input logic ack, input logic [63:0] mrd);
        bit exp_ig, exp_dg;
        @(posedge CLK);
        #1;
        i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_wstrb = ds;
        m_ack = ack; m_rdata = mrd;
        @(negedge CLK);
        exp_ig = 0;
        exp_dg = 0;
        if (!busy) begin
            if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
                exp_dg = prefer_d;
                exp_ig = !prefer_d;
`else
                exp_dg = 1;
`endif
            end else begin
                exp_ig = ir;
                exp_dg = dr;
            end
        end
        check("i_gnt", i_gnt, exp_ig);
        check("d_gnt", d_gnt, exp_dg);
        check("m_req", m_req, busy);
        if (busy) begin
            check("m_addr", m_addr, t_addr);
            check("m_we", m_we, t_we);
            check("m_wstrb", m_wstrb, t_wstrb);
            if (owner_d) check("m_wdata", m_wdata, t_wdata);
        end
        check("i_rvalid", i_rvalid, rv_i);
        check("d_rvalid", d_rvalid, rv_d);
        if (rv_i || rv_d) begin
            check("rerr", rerr, rv_err);
            check("rdata", rdata, rv_data);
        end
        // advance the model to the next cycle
        rv_i = 0;
        rv_d = 0;
        if (busy) begin
            if (ack) begin
                busy = 0; rv_i = !owner_d; rv_d = owner_d; rv_err = 0; rv_data = mrd;
            end else begin
                age++;
                if (age == TO) begin
                    busy = 0; rv_i = !owner_d; rv_d = owner_d; rv_err = 1; rv_data = '0;
                end
            end
        end else if (exp_ig || exp_dg) begin
            busy     = 1;
            age      = 0;
            owner_d  = exp_dg;
            prefer_d = exp_ig;
            t_addr   = exp_dg ? da : ia;
            t_we     = exp_dg ? dw : 1'b0;
            t_wdata  = dwd;
            t_wstrb  = exp_dg ? ds : 8'h00;
        end
    endtask

    task automatic idle_step(input logic ack, input logic [63:0] mrd);
        step(0, '0, 0, 0, '0, '0, '0, ack, mrd);
    endtask

    // Reset pulse placed mid-cycle with both requests raised
    task automatic pulse_reset();
        #1;
        RSTn  = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_m_wstrb", m_wstrb, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rerr", rerr, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        model_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        logic [63:0] a, w, r;
        RSTn = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; m_rdata = '0;
        model_reset();
        // power-on reset
        pulse_reset();

        // fetch, single-cycle ack; an ack while idle must be ignored first
        idle_step(1, 64'hdead);
        step(1, 64'h8000_0000, 0, 0, '0, '0, '0, 0, '0);
        idle_step(1, 64'h0123_4567_89ab_cdef);
        idle_step(0, '0);
        check("fetch_rvalid", i_rvalid, 1);
        check("fetch_rdata", rdata, 64'h0123_4567_89ab_cdef);

        // tie: first winner, then fetch granted in the rvalid cycle
        step(1, 64'h100, 1, 0, 64'h200, '0, 8'hff, 0, '0);
        idle_step(1, 64'h55);
        step(1, 64'h100, 0, 0, '0, '0, '0, 0, '0);
        // second tie right after
        idle_step(1, 64'h66);
        step(1, 64'h104, 1, 0, 64'h204, '0, 8'hff, 0, '0);
        idle_step(1, 64'h77);
        idle_step(0, '0);

        // store held off 5 cycles, acked on the 6th
        step(0, '0, 1, 1, 64'h3000, 64'h1122_3344_5566_7788, 8'h0f, 0, '0);
        repeat (5) idle_step(0, '0);
        check("store_m_we", m_we, 1);
        idle_step(1, 64'h99);
        idle_step(0, '0);
        check("store_rvalid", d_rvalid, 1);
        check("store_rerr", rerr, 0);

        // watchdog: never acked
        step(1, 64'h4000, 0, 0, '0, '0, '0, 0, '0);
        repeat (TO) idle_step(0, '0);
        idle_step(0, '0);
        check("to_m_req", m_req, 0);
        check("to_rerr", rerr, 1);
        check("to_rdata", rdata, 0);
        // watchdog: ack in the expiry cycle is a normal completion
        step(0, '0, 1, 0, 64'h4100, '0, 8'h00, 0, '0);
        repeat (TO - 1) idle_step(0, '0);
        idle_step(1, 64'habcd);
        idle_step(0, '0);
        check("late_ack_rerr", rerr, 0);
        check("late_ack_rdata", rdata, 64'habcd);

        // reset mid-busy, then a normal transaction
        step(0, '0, 1, 1, 64'h5000, 64'h1, 8'h01, 0, '0);
        idle_step(0, '0);
        pulse_reset();
        idle_step(1, 64'h1);
        step(1, 64'h6000, 0, 0, '0, '0, '0, 0, '0);
        idle_step(1, 64'h42);
        idle_step(0, '0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            a = {$urandom, $urandom};
            w = {$urandom, $urandom};
            r = {$urandom, $urandom};
            step(($urandom % 4) != 0, {$urandom, $urandom},
                 ($urandom % 3) != 0, $urandom_range(0, 1), a, w, 8'($urandom),
                 ($urandom % 10) < 3, r);
            if (n % 900 == 450) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
